// File: rtl/cache_rd_arbiter_pkg.sv
// Shared cache definitions: line geometry, read-arbiter FSM encoding and the way bus.
package cache_rd_arbiter_pkg;
  localparam int LINE_WORDS_DEF = 8;
  localparam int LINE_W         = 32 * LINE_WORDS_DEF;
  localparam int TAG_W          = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } WayBus;

  // Align an address down to the start of its cache line.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int words);
    line_base = addr & ~32'(4 * words - 1);
  endfunction
endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,   // bit0 = icache, bit1 = dcache
  input  logic       last_i,  // 1 = dcache was granted last
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
    else                gnt_o = req_i;
  end
endmodule

// File: rtl/cache_rd_arbiter.sv
// Arbitrates icache/dcache line reads onto one AXI read port and assembles the
// returned beats into a line buffer shared by both requesters.
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_rreq_i,
  input  logic [31:0]             ic_raddr_i,
  input  logic                    ic_cached_i,
  output logic                    ic_rend_o,
  output logic [32*LINE_WORDS-1:0] ic_rdata_o,
  input  logic                    dc_rreq_i,
  input  logic [31:0]             dc_raddr_i,
  input  logic                    dc_cached_i,
  output logic                    dc_rend_o,
  output logic [32*LINE_WORDS-1:0] dc_rdata_o,
  output logic                    axi_arvalid_o,
  output logic [31:0]             axi_araddr_o,
  output logic [7:0]              axi_arlen_o,
  input  logic                    axi_arready_i,
  input  logic                    axi_rvalid_i,
  input  logic [31:0]             axi_rdata_i,
  input  logic                    axi_rlast_i,
  output logic                    axi_rready_o
);
  localparam logic [3:0] CNT_MAX = 4'(LINE_WORDS);

  rd_state_e                 state_q, state_d;
  logic                      gnt_dc_q, gnt_dc_d;
  logic                      last_dc_q, last_dc_d;
  logic [1:0]                mask_q, mask_d;
  logic [31:0]               addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [32*LINE_WORDS-1:0]  line_q, line_d;
  logic                      arvalid_q, rready_q, ic_rend_q, dc_rend_q;

  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic        sel_cached;

  // The requester just served is masked for the one IDLE cycle after RESP.
  rr_arb2 u_rr (
    .req_i  ({dc_rreq_i, ic_rreq_i} & ~mask_q),
    .last_i (last_dc_q),
    .gnt_o  (gnt)
  );

  assign sel_addr   = gnt[1] ? dc_raddr_i  : ic_raddr_i;
  assign sel_cached = gnt[1] ? dc_cached_i : ic_cached_i;

  always_comb begin
    state_d   = state_q;
    gnt_dc_d  = gnt_dc_q;
    last_dc_d = last_dc_q;
    mask_d    = 2'b00;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          state_d  = S_AR;
          gnt_dc_d = gnt[1];
          addr_d   = sel_cached ? line_base(sel_addr, LINE_WORDS) : sel_addr;
          len_d    = sel_cached ? 8'(LINE_WORDS - 1) : 8'd0;
          cnt_d    = 4'd0;
          line_d   = '0;
        end
      end
      S_AR: if (axi_arready_i) state_d = S_R;
      S_R: begin
        if (axi_rvalid_i) begin
          // Beats past the end of the line are dropped; the counter saturates.
          if (cnt_q < CNT_MAX) begin
            for (int i = 0; i < LINE_WORDS; i++)
              if (cnt_q == 4'(i)) line_d[32*i +: 32] = axi_rdata_i;
            cnt_d = cnt_q + 4'd1;
          end
          if (axi_rlast_i) state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        last_dc_d = gnt_dc_q;
        mask_d    = gnt_dc_q ? 2'b10 : 2'b01;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_dc_q  <= 1'b0;
      last_dc_q <= 1'b0;
      mask_q    <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      line_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ic_rend_q <= 1'b0;
      dc_rend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_dc_q  <= gnt_dc_d;
      last_dc_q <= last_dc_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      arvalid_q <= (state_d == S_AR);
      rready_q  <= (state_d == S_R);
      ic_rend_q <= (state_d == S_RESP) && !gnt_dc_d;
      dc_rend_q <= (state_d == S_RESP) &&  gnt_dc_d;
    end
  end

  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = len_q;
  assign axi_rready_o  = rready_q;
  assign ic_rend_o     = ic_rend_q;
  assign dc_rend_o     = dc_rend_q;
  assign ic_rdata_o    = line_q;
  assign dc_rdata_o    = line_q;
endmodule
